// File: rtl/alu_resp_unit.sv
// ============================================================================
//  Module   : alu_resp_unit
//  Brief    : Handshaked ALU responder (AND/OR/ADD/SUB/SLT-family/NOR) with a
//             2-entry in-order response FIFO and accepted-request counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_resp_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    input  logic [2:0]       bonus_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       zcv,
    output logic             err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;
    localparam int         ENT_W  = WIDTH + 4;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             add_ovf;
    logic             sub_ovf;
    logic             lt;
    logic             eq;
    logic             cmp;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    logic             alu_err;
    logic             alu_zero;

    logic [ENT_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    assign sum_ext  = {1'b0, src1} + {1'b0, src2};
    assign diff_ext = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf  = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum_ext[WIDTH-1] != src1[WIDTH-1]);
    assign sub_ovf  = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff_ext[WIDTH-1] != src1[WIDTH-1]);
    assign lt       = diff_ext[WIDTH-1] ^ sub_ovf;
    assign eq       = (src1 == src2);

    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        cmp      = 1'b0;
        case (ALU_control)
            OP_AND: alu_res = src1 & src2;
            OP_OR:  alu_res = src1 | src2;
            OP_NOR: alu_res = ~(src1 | src2);
            OP_ADD: begin
                alu_res  = sum_ext[WIDTH-1:0];
                alu_cout = sum_ext[WIDTH];
                alu_ovf  = add_ovf;
            end
            OP_SUB: begin
                alu_res  = diff_ext[WIDTH-1:0];
                alu_cout = diff_ext[WIDTH];
                alu_ovf  = sub_ovf;
            end
            OP_SLT: begin
                case (bonus_control)
                    3'b000:  cmp = lt;
                    3'b001:  cmp = !lt && !eq;
                    3'b010:  cmp = lt || eq;
                    3'b011:  cmp = !lt;
                    3'b100:  cmp = eq;
                    3'b101:  cmp = !eq;
                    default: alu_err = 1'b1;
                endcase
                alu_res = {{(WIDTH-1){1'b0}}, cmp};
            end
            default: alu_err = 1'b1;
        endcase
    end

    // Illegal requests leave result at 0, so zero=1 yields the required zcv=100.
    assign alu_zero = (alu_res == '0);

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            op_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {alu_err, alu_zero, alu_cout, alu_ovf, alu_res};
                wr_ptr      <= ~wr_ptr;
                op_count    <= op_count + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head   = mem[rd_ptr];
    assign result = out_valid ? head[WIDTH-1:0]       : '0;
    assign zcv    = out_valid ? head[WIDTH+2:WIDTH]   : 3'b000;
    assign err    = out_valid ? head[WIDTH+3]         : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_alu_resp_unit.sv
// ============================================================================
//  Module   : tb_alu_resp_unit
//  Brief    : Directed scoreboard bench for alu_resp_unit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_resp_unit;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flags;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ALU_control;
    logic [2:0]  bonus_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  zcv;
    logic        err;
    logic [15:0] op_count;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          exp_ops = 0;

    alu_resp_unit #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2),
        .ALU_control(ALU_control), .bonus_control(bonus_control),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zcv(zcv), .err(err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive a request and record its expected response.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic [2:0] bc, input logic [31:0] er, input logic [2:0] ez,
                         input logic ee);
        exp_t x;
        src1          = a;
        src2          = b;
        ALU_control   = op;
        bonus_control = bc;
        in_valid      = 1'b1;
        x.res = er; x.flags = ez; x.e = ee;
        sb.push_back(x);
        exp_ops++;
    endtask

    // Called at a negedge: run until every expected response has been compared.
    task automatic drain(input string tag);
        logic acc;
        exp_t x;
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            if (out_valid) begin
                x = sb.pop_front();
                chk({tag, "_result"}, result, x.res);
                chk({tag, "_zcv"}, {29'b0, zcv}, {29'b0, x.flags});
                chk({tag, "_err"}, {31'b0, err}, {31'b0, x.e});
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_pending"}, sb.size(), 0);
    endtask

    task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [2:0] bc, input logic [31:0] er,
                        input logic [2:0] ez, input logic ee);
        issue(a, b, op, bc, er, ez, ee);
        drain(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        src1 = '0; src2 = '0; ALU_control = '0; bonus_control = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_result", result, 0);
        chk("rst_zcv", {29'b0, zcv}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_op_count", {16'b0, op_count}, 0);
        rst = 1'b0;
        @(negedge clk);

        run1("add_ovf",  32'h7FFFFFFF, 32'h1, 4'd2, 3'd0, 32'h80000000, 3'b001, 1'b0);
        run1("add_wrap", 32'hFFFFFFFF, 32'h1, 4'd2, 3'd0, 32'h0,        3'b110, 1'b0);
        run1("sub_eq",   32'd5, 32'd5,        4'd6, 3'd0, 32'h0,        3'b110, 1'b0);
        run1("sub_ovf",  32'h80000000, 32'h1, 4'd6, 3'd0, 32'h7FFFFFFF, 3'b011, 1'b0);
        run1("sub_neg",  32'd1, 32'd2,        4'd6, 3'd0, 32'hFFFFFFFF, 3'b000, 1'b0);
        run1("slt",      32'hFFFFFFFF, 32'h1, 4'd7, 3'd0, 32'h1,        3'b000, 1'b0);
        run1("sgt",      32'hFFFFFFFF, 32'h1, 4'd7, 3'd1, 32'h0,        3'b100, 1'b0);
        run1("sle",      32'hFFFFFFFF, 32'h1, 4'd7, 3'd2, 32'h1,        3'b000, 1'b0);
        run1("sge",      32'hFFFFFFFF, 32'h1, 4'd7, 3'd3, 32'h0,        3'b100, 1'b0);
        run1("seq",      32'd7, 32'd7,        4'd7, 3'd4, 32'h1,        3'b000, 1'b0);
        run1("sne",      32'd7, 32'd7,        4'd7, 3'd5, 32'h0,        3'b100, 1'b0);
        run1("and",      32'hF0F0F0F0, 32'h0F0F0F0F, 4'd0, 3'd0, 32'h0, 3'b100, 1'b0);
        run1("or",       32'h12340000, 32'h00005678, 4'd1, 3'd0, 32'h12345678, 3'b000, 1'b0);
        run1("nor",      32'h0, 32'h0,        4'd12, 3'd0, 32'hFFFFFFFF, 3'b000, 1'b0);
        run1("bad_bonus", 32'd3, 32'd9,       4'd7, 3'd6, 32'h0,        3'b100, 1'b1);
        run1("bad_op",   32'd3, 32'd9,        4'd3, 3'd0, 32'h0,        3'b100, 1'b1);
        chk("op_count_after_illegal", {16'b0, op_count}, exp_ops);

        // Streaming at one request per cycle with the consumer always ready.
        issue(32'd10, 32'd1, 4'd2, 3'd0, 32'd11, 3'b000, 1'b0);
        @(posedge clk); #1;
        issue(32'd20, 32'd1, 4'd2, 3'd0, 32'd21, 3'b000, 1'b0);
        @(negedge clk);
        chk("stream_in_ready", {31'b0, in_ready}, 1);
        drain("stream");

        // Backpressure: two accepted, third held until a pop frees a slot.
        out_ready = 1'b0;
        issue(32'd1, 32'd1, 4'd2, 3'd0, 32'd2, 3'b000, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_one", {31'b0, in_ready}, 1);
        issue(32'd2, 32'd2, 4'd2, 3'd0, 32'd4, 3'b000, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_full", {31'b0, in_ready}, 0);
        issue(32'd3, 32'd3, 4'd2, 3'd0, 32'd6, 3'b000, 1'b0);
        repeat (2) @(negedge clk);
        chk("bp_held_in_ready", {31'b0, in_ready}, 0);
        chk("bp_held_op_count", {16'b0, op_count}, exp_ops - 1);
        chk("bp_head_stable", result, 32'd2);
        chk("bp_out_valid", {31'b0, out_valid}, 1);
        out_ready = 1'b1;
        drain("bp");
        chk("bp_op_count", {16'b0, op_count}, exp_ops);

        // Asynchronous reset with two entries queued.
        out_ready = 1'b0;
        issue(32'd4, 32'd4, 4'd2, 3'd0, 32'd8, 3'b000, 1'b0);
        @(posedge clk); #1;
        issue(32'd5, 32'd5, 4'd2, 3'd0, 32'd10, 3'b000, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_in_ready", {31'b0, in_ready}, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 0);
        chk("arst_op_count", {16'b0, op_count}, 0);
        chk("arst_in_ready", {31'b0, in_ready}, 1);
        chk("arst_result", result, 0);
        sb.delete();
        exp_ops = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        run1("post_rst", 32'h0000FFFF, 32'h00000001, 4'd2, 3'd0, 32'h00010000, 3'b000, 1'b0);
        chk("post_rst_op_count", {16'b0, op_count}, exp_ops);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
